// File: rtl/fb_line_fetcher.sv
// Framebuffer line fetcher: on line_start, reads one row of WORDS_PER_LINE words from a
// synchronous RAM and feeds them to the pixel shifter. It follows the shifter's pixel and
// repeat counters, so the next word is already on d before the shifter reloads.
// Latency: read at T1, word0 on d at T3 with load, word1 on d from T6, later words 3 cycles
// after each reload. After the last word, d is 0 so the shifter reloads blank pixels.
// Flow control: enable low freezes all counters. line_start aborts any line in progress.
// Ports:
//   clk, reset        pixel clock, asynchronous active-high reset
//   line_start, row   1-cycle start pulse and the row index sampled with it
//   enable, mult      shifter enable and pixel repeat count less one (same as the shifter)
//   mem_addr, mem_rd  RAM read address and 1-cycle read strobe (data on mem_data next cycle)
//   mem_data          RAM read data
//   d, load           word to the shifter and its 1-cycle load pulse
//   active            high from line_start until the last word of the row is consumed
module fb_line_fetcher #(
  parameter int WIDTH          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ROW_W          = 5,
  parameter int ADDR_W         = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [ROW_W-1:0]  row,
  input  logic              enable,
  input  logic [3:0]        mult,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WIDTH-1:0]  mem_data,
  output logic [WIDTH-1:0]  d,
  output logic              load,
  output logic              active
);

  localparam int PW = $clog2(WIDTH);
  localparam int KW = $clog2(WORDS_PER_LINE + 1);

  typedef enum logic [2:0] {IDLE, RD0, LAT0, LOAD, RDN, LATN, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [3:0]        sub, sub_nxt;
  logic [PW-1:0]     pix, pix_nxt;
  logic [KW-1:0]     k, k_nxt;
  logic [WIDTH-1:0]  d_nxt;
  logic              load_nxt, rd_nxt, active_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  logic [ADDR_W-1:0] new_base;
  logic              counting, last_word, more_reads;

  assign new_base = ADDR_W'(row) * ADDR_W'(WORDS_PER_LINE);
  // The shifter is running once word0 has been loaded, whether or not a read is in flight.
  assign counting   = (state == RDN) || (state == LATN) || (state == RUN);
  assign last_word  = (k == KW'(WORDS_PER_LINE - 1));
  // On a reload, word k+1 enters the shifter. Word k+2 must be fetched if it exists.
  assign more_reads = (int'(k) + 2) < WORDS_PER_LINE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      base     <= '0;
      sub      <= '0;
      pix      <= '0;
      k        <= '0;
      d        <= '0;
      load     <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      active   <= 1'b0;
    end else begin
      state    <= state_nxt;
      base     <= base_nxt;
      sub      <= sub_nxt;
      pix      <= pix_nxt;
      k        <= k_nxt;
      d        <= d_nxt;
      load     <= load_nxt;
      mem_rd   <= rd_nxt;
      mem_addr <= addr_nxt;
      active   <= active_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    base_nxt   = base;
    sub_nxt    = sub;
    pix_nxt    = pix;
    k_nxt      = k;
    d_nxt      = d;
    load_nxt   = 1'b0;
    rd_nxt     = 1'b0;
    addr_nxt   = mem_addr;
    active_nxt = active;

    case (state)
      RD0: state_nxt = LAT0;
      LAT0: begin
        d_nxt     = mem_data;
        load_nxt  = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        // The shifter loads at the end of this cycle. Counting restarts from zero here.
        sub_nxt   = '0;
        pix_nxt   = '0;
        k_nxt     = '0;
        rd_nxt    = 1'b1;
        addr_nxt  = base + ADDR_W'(1);
        state_nxt = RDN;
      end
      RDN: state_nxt = LATN;
      LATN: begin
        d_nxt     = mem_data;
        state_nxt = RUN;
      end
      default: ;
    endcase

    if (counting && enable) begin
      if (sub == mult) begin
        sub_nxt = '0;
        if (pix == PW'(WIDTH - 1)) begin
          // The shifter reloads from d on this cycle.
          pix_nxt = '0;
          if (last_word) begin
            k_nxt      = '0;
            active_nxt = 1'b0;
            state_nxt  = IDLE;
          end else begin
            k_nxt = k + KW'(1);
            if (more_reads) begin
              rd_nxt    = 1'b1;
              addr_nxt  = base + ADDR_W'(k) + ADDR_W'(2);
              state_nxt = RDN;
            end else begin
              // The final word has just entered the shifter. Blank follows it.
              d_nxt = '0;
            end
          end
        end else begin
          pix_nxt = pix + PW'(1);
        end
      end else begin
        sub_nxt = sub + 4'd1;
      end
    end

    // A new line overrides everything. Hold d so that no data from the old row is captured.
    if (line_start) begin
      state_nxt  = RD0;
      base_nxt   = new_base;
      sub_nxt    = '0;
      pix_nxt    = '0;
      k_nxt      = '0;
      d_nxt      = d;
      load_nxt   = 1'b0;
      rd_nxt     = 1'b1;
      addr_nxt   = new_base;
      active_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_line_fetcher.sv
// Bench for fb_line_fetcher. It uses a RAM model, a downstream pixel shifter model, and a
// scoreboard of expected read addresses, load words and pixel stream.
// Ports: none. It drives the DUT and prints one Result line.
module tb_fb_line_fetcher;
  localparam int WIDTH  = 16;
  localparam int WPL    = 4;
  localparam int ROW_W  = 5;
  localparam int ADDR_W = 7;
  localparam int BIG    = 1000000;

  logic              clk = 1'b0;
  logic              rst;
  logic              line_start;
  logic [ROW_W-1:0]  row;
  logic              enable;
  logic [3:0]        mult;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [WIDTH-1:0]  mem_data;
  logic [WIDTH-1:0]  d;
  logic              load;
  logic              active;

  logic [WIDTH-1:0]  ram [0:127];

  int errors = 0;
  int checks = 0;
  int rd_seen = 0;

  logic [ADDR_W-1:0] addr_q [$];
  logic [WIDTH-1:0]  load_q [$];
  bit                pix_q  [$];

  // Downstream shifter: it loads d on load, shifts MSB-first every mult+1 enabled cycles,
  // and reloads from d after WIDTH pixels.
  logic [WIDTH-1:0]  sh;
  int                sh_sub, sh_pix;
  bit                sh_live;

  always #5 clk = ~clk;

  fb_line_fetcher #(.WIDTH(WIDTH), .WORDS_PER_LINE(WPL), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(rst), .line_start(line_start), .row(row), .enable(enable),
    .mult(mult), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .d(d), .load(load), .active(active)
  );

  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0; sh_sub <= 0; sh_pix <= 0; sh_live <= 1'b0;
    end else if (load) begin
      sh <= d; sh_sub <= 0; sh_pix <= 0; sh_live <= 1'b1;
    end else if (enable) begin
      if (sh_sub == int'(mult)) begin
        sh_sub <= 0;
        if (sh_pix == WIDTH - 1) begin
          sh_pix <= 0; sh <= d;
        end else begin
          sh_pix <= sh_pix + 1; sh <= sh << 1;
        end
      end else begin
        sh_sub <= sh_sub + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a read, a load or a pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_rd) begin
          rd_seen++;
          if (addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: got addr %0d expected no read at %0t", mem_addr, $time);
          end else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
        if (load) begin
          if (load_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_load: got d %0h expected no load at %0t", d, $time);
          end else check("load_d", 32'(d), 32'(load_q.pop_front()));
        end
        if (enable && sh_live && pix_q.size() > 0)
          check("pixel", 32'(sh[WIDTH-1]), 32'(pix_q.pop_front()));
      end
    end
  end

  // One line. en_mode<0 toggles enable, otherwise it is the enable percentage. The task
  // stops early after max_en enabled cycles. hold>0 freezes enable for that many cycles at T6.
  task automatic run_line(input int r, input int m, input int en_mode, input int max_en,
                          input int hold);
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] w1;
    int idx, en_cnt, rd0;
    bit en;
    @(posedge clk); #1;
    addr_q.delete(); load_q.delete(); pix_q.delete();
    for (int i = 0; i < WPL; i++) begin
      w = ram[ADDR_W'(r * WPL + i)];
      addr_q.push_back(ADDR_W'(r * WPL + i));
      if (i == 0) load_q.push_back(w);
      for (int b = WIDTH - 1; b >= 0; b--)
        for (int rep = 0; rep <= m; rep++) pix_q.push_back(w[b]);
    end
    repeat (8) pix_q.push_back(1'b0);
    w1 = ram[ADDR_W'(r * WPL + 1)];
    line_start = 1'b1; row = ROW_W'(r); mult = 4'(m); enable = 1'b0;
    @(posedge clk); #1;
    line_start = 1'b0;
    check("active_T1", 32'(active), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    idx = 0; en_cnt = 0;
    while (pix_q.size() > 0 && en_cnt < max_en) begin
      if (idx == 2) begin
        check("d_word1_T6", 32'(d), 32'(w1));
        check("active_run", 32'(active), 32'd1);
        if (hold > 0) begin
          enable = 1'b0;
          rd0 = rd_seen;
          repeat (hold) @(posedge clk);
          #1;
          check("hold_d", 32'(d), 32'(w1));
          check("hold_active", 32'(active), 32'd1);
          check("hold_no_rd", 32'(rd_seen), 32'(rd0));
        end
      end
      if (idx >= 6000) begin
        checks++; errors++;
        $display("FAIL line_timeout: got %0d pixels pending expected 0", pix_q.size());
        pix_q.delete();
        break;
      end
      if (en_mode < 0) en = (idx % 2) == 0;
      else en = $urandom_range(0, 99) < en_mode;
      enable = en;
      if (en) en_cnt++;
      @(posedge clk); #1;
      idx++;
    end
    enable = 1'b0;
    if (en_cnt < max_en) begin
      check("active_end", 32'(active), 32'd0);
      check("reads_left", 32'(addr_q.size()), 32'd0);
      check("loads_left", 32'(load_q.size()), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; line_start = 1'b0; enable = 1'b0; row = '0; mult = '0;
    for (int i = 0; i < 128; i++) ram[i] = WIDTH'($urandom);
    ram[0] = 16'hF00F; ram[1] = 16'h1234; ram[2] = 16'hAAAA; ram[3] = 16'h5555;

    // Reset with the clock running, then release between edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_d", 32'(d), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    #3 rst = 1'b0;

    // Row 0, mult 0, enable held high.
    run_line(0, 0, 100, BIG, 0);
    // Last row, mult 3, enable toggling.
    run_line(31, 3, -1, BIG, 0);
    // Abort while word1 is in the shifter, then restart on row 5.
    run_line(0, 0, 100, 24, 0);
    run_line(5, 0, 100, BIG, 0);
    // Reset in RUN after the second read, then a normal line.
    run_line(9, 0, 100, 5, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_d", 32'(d), 32'd0);
    check("midrst_load", 32'(load), 32'd0);
    check("midrst_mem_rd", 32'(mem_rd), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    addr_q.delete(); load_q.delete(); pix_q.delete();
    @(posedge clk); #3 rst = 1'b0;
    run_line(12, 1, 70, BIG, 0);
    // Long enable stall after LATN.
    run_line(3, 2, 80, BIG, 500);
    // Randomized lines.
    for (int n = 0; n < 6; n++)
      run_line(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
               int'($urandom_range(30, 100)), BIG, 0);
    run_line(int'($urandom_range(0, 31)), 7, 60, BIG, 0);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
